ad9467_iodelay_cal: RTL and testbench



---
 rtl/ad9467_pkg.sv | 33 +++
 rtl/ad9467_cal_window.sv | 70 +++++++
 rtl/ad9467_iodelay_cal.sv | 201 ++++++++++++++++++++
 tb/tb_ad9467_iodelay_cal.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9467_pkg.sv
// Shared constants, state encoding and helpers for the AD9467 IDELAY calibration block.
package ad9467_pkg;

    localparam int NUM_LANES    = 8;
    localparam int TAP_W        = 5;
    localparam int NUM_TAPS     = 32;
    localparam int LANE_FIELD_W = 8;
    localparam int LEN_W        = TAP_W + 1;   // run lengths go up to NUM_TAPS
    localparam int DATA_W       = NUM_LANES * LANE_FIELD_W;

    // Checkerboard test pattern words; per lane these are 2'b01 / 2'b10
    localparam logic [15:0] PAT_A = 16'h5555;
    localparam logic [15:0] PAT_B = 16'hAAAA;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_NEXT   = 3'd4;
    localparam state_t ST_EVAL   = 3'd5;
    localparam state_t ST_APPLY  = 3'd6;
    localparam state_t ST_DONE   = 3'd7;

    // Same tap in every lane field, reserved bits zero
    function automatic logic [DATA_W-1:0] bcast_tap(input logic [TAP_W-1:0] tap);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_LANES; i++) w[i*LANE_FIELD_W +: TAP_W] = tap;
        return w;
    endfunction

endpackage

// File: rtl/ad9467_cal_window.sv
// Per-lane streaming longest-run finder over the 32-entry pass map.
// Outputs are derived from the next-state best run so the top can register
// the final tap on the same edge that consumes k=31.
module ad9467_cal_window
    import ad9467_pkg::*;
#(
    parameter logic [TAP_W-1:0] TAP_DEFAULT = 5'd0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             first,
    input  logic             last,
    input  logic             pass,
    input  logic [TAP_W-1:0] k,
    output logic [TAP_W-1:0] tap,
    output logic             err
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [LEN_W-1:0] cur_len_in, best_len_in, run_len, half;
    logic [TAP_W-1:0] best_start_in, run_start;

    // Extend or close the current run; a closed run wins only if strictly longer
    always_comb begin
        cur_len_in    = first ? '0 : cur_len_q;
        best_len_in   = first ? '0 : best_len_q;
        best_start_in = first ? '0 : best_start_q;
        run_start     = (cur_len_in == '0) ? k : cur_start_q;
        run_len       = cur_len_in + LEN_W'(pass);
        cur_start_d   = cur_start_q;
        cur_len_d     = cur_len_q;
        best_start_d  = best_start_q;
        best_len_d    = best_len_q;
        if (en) begin
            cur_start_d  = run_start;
            cur_len_d    = pass ? run_len : '0;
            best_start_d = best_start_in;
            best_len_d   = best_len_in;
            if ((!pass || last) && (run_len > best_len_in)) begin
                best_start_d = run_start;
                best_len_d   = run_len;
            end
        end
    end

    // Centre of the best run, rounded towards its start
    always_comb begin
        half = (best_len_d - LEN_W'(1)) >> 1;
        err  = (best_len_d == '0);
        tap  = err ? TAP_DEFAULT : (best_start_d + half[TAP_W-1:0]);
    end

    // Run tracking registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

endmodule

// File: rtl/ad9467_iodelay_cal.sv
// IDELAY tap calibration sequencer: sweeps all lanes over taps 0..31 against
// the checkerboard pattern, then loads the centre of each lane's best window.
module ad9467_iodelay_cal
    import ad9467_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 16,
    parameter int               WINDOW        = 256,
    parameter logic [TAP_W-1:0] TAP_DEFAULT   = 5'd0
) (
    input  logic        adc_clk,
    input  logic        adc_resetn,
    input  logic        cal_start,
    input  logic        iodelay_ready,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic [63:0] iodelay_data,
    output logic        iodelay_load,
    output logic        cal_busy,
    output logic        cal_done,
    output logic [7:0]  cal_error
);

    localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WINDOW - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(NUM_TAPS - 1);

    state_t                                 state_q, state_d;
    logic [TAP_W-1:0]                       tap_q, tap_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [15:0]                            prev_smp_q, prev_smp_d;
    logic [NUM_LANES-1:0]                   lane_fail_q, lane_fail_d;
    logic [NUM_LANES-1:0][NUM_TAPS-1:0]     pass_map_q, pass_map_d;
    logic [DATA_W-1:0]                      prev_data_q, prev_data_d;
    logic [DATA_W-1:0]                      iodelay_data_q, iodelay_data_d;
    logic                                   iodelay_load_q, iodelay_load_d;
    logic                                   cal_busy_q, cal_busy_d;
    logic                                   cal_done_q, cal_done_d;
    logic [NUM_LANES-1:0]                   cal_error_q, cal_error_d;

    logic [NUM_LANES-1:0]                   smp_fail;
    logic [NUM_LANES-1:0][TAP_W-1:0]        win_tap;
    logic [NUM_LANES-1:0]                   win_err;
    logic                                   eval_en;

    assign eval_en = (state_q == ST_EVAL);

    // Per-lane failure of the current sample: bad code or missing toggle
    always_comb begin
        smp_fail = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            smp_fail[i] = !((adc_data[2*i +: 2] == PAT_A[2*i +: 2]) ||
                            (adc_data[2*i +: 2] == PAT_B[2*i +: 2])) ||
                          ((cnt_q != '0) && (adc_data[2*i +: 2] == prev_smp_q[2*i +: 2]));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_win
        ad9467_cal_window #(.TAP_DEFAULT(TAP_DEFAULT)) u_win (
            .clk    (adc_clk),
            .resetn (adc_resetn),
            .en     (eval_en),
            .first  (tap_q == '0),
            .last   (tap_q == TAP_LAST),
            .pass   (pass_map_q[g][tap_q]),
            .k      (tap_q),
            .tap    (win_tap[g]),
            .err    (win_err[g])
        );
    end

    // Sequencer; outputs are registered and set on entry to the state that owns them
    always_comb begin
        state_d        = state_q;
        tap_d          = tap_q;
        cnt_d          = cnt_q;
        prev_smp_d     = prev_smp_q;
        lane_fail_d    = lane_fail_q;
        pass_map_d     = pass_map_q;
        prev_data_d    = prev_data_q;
        iodelay_data_d = iodelay_data_q;
        iodelay_load_d = 1'b0;
        cal_busy_d     = cal_busy_q;
        cal_done_d     = cal_done_q;
        cal_error_d    = cal_error_q;
        case (state_q)
            ST_IDLE: begin
                if (cal_start && iodelay_ready) begin
                    state_d        = ST_LOAD;
                    cal_busy_d     = 1'b1;
                    cal_done_d     = 1'b0;
                    cal_error_d    = '0;
                    prev_data_d    = iodelay_data_q;
                    tap_d          = '0;
                    iodelay_load_d = 1'b1;
                    iodelay_data_d = bcast_tap('0);
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = ST_CHECK;
                    cnt_d       = '0;
                    lane_fail_d = '0;
                    prev_smp_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (adc_valid) begin
                    lane_fail_d = lane_fail_q | smp_fail;
                    prev_smp_d  = adc_data;
                    if (cnt_q == WIN_LAST) state_d = ST_NEXT;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_NEXT: begin
                for (int i = 0; i < NUM_LANES; i++) pass_map_d[i][tap_q] = ~lane_fail_q[i];
                if (tap_q == TAP_LAST) begin
                    state_d = ST_EVAL;
                    tap_d   = '0;
                end else begin
                    state_d        = ST_LOAD;
                    tap_d          = tap_q + 1'b1;
                    iodelay_load_d = 1'b1;
                    iodelay_data_d = bcast_tap(tap_q + 1'b1);
                end
            end
            ST_EVAL: begin
                if (tap_q == TAP_LAST) begin
                    state_d        = ST_APPLY;
                    iodelay_load_d = 1'b1;
                    iodelay_data_d = '0;
                    for (int i = 0; i < NUM_LANES; i++)
                        iodelay_data_d[i*LANE_FIELD_W +: TAP_W] = win_tap[i];
                    cal_error_d    = win_err;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_APPLY: begin
                state_d    = ST_DONE;
                cal_busy_d = 1'b0;
                cal_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Losing IDELAYCTRL ready restores the pre-calibration taps, overriding any transition
        if (cal_busy_q && !iodelay_ready) begin
            state_d        = ST_IDLE;
            iodelay_data_d = prev_data_q;
            iodelay_load_d = 1'b1;
            cal_error_d    = '1;
            cal_done_d     = 1'b1;
            cal_busy_d     = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge adc_clk) begin
        if (!adc_resetn) begin
            state_q        <= ST_IDLE;
            tap_q          <= '0;
            cnt_q          <= '0;
            prev_smp_q     <= '0;
            lane_fail_q    <= '0;
            pass_map_q     <= '0;
            prev_data_q    <= bcast_tap(TAP_DEFAULT);
            iodelay_data_q <= bcast_tap(TAP_DEFAULT);
            iodelay_load_q <= 1'b0;
            cal_busy_q     <= 1'b0;
            cal_done_q     <= 1'b0;
            cal_error_q    <= '0;
        end else begin
            state_q        <= state_d;
            tap_q          <= tap_d;
            cnt_q          <= cnt_d;
            prev_smp_q     <= prev_smp_d;
            lane_fail_q    <= lane_fail_d;
            pass_map_q     <= pass_map_d;
            prev_data_q    <= prev_data_d;
            iodelay_data_q <= iodelay_data_d;
            iodelay_load_q <= iodelay_load_d;
            cal_busy_q     <= cal_busy_d;
            cal_done_q     <= cal_done_d;
            cal_error_q    <= cal_error_d;
        end
    end

    assign iodelay_data = iodelay_data_q;
    assign iodelay_load = iodelay_load_q;
    assign cal_busy     = cal_busy_q;
    assign cal_done     = cal_done_q;
    assign cal_error    = cal_error_q;

endmodule

// File: tb/tb_ad9467_iodelay_cal.sv
// Bench for ad9467_iodelay_cal: an ADC model produces the checkerboard per lane
// according to a per-tap pass mask; expected results go into a queue that a
// monitor drains whenever cal_done rises.
module tb_ad9467_iodelay_cal;

    localparam int S   = 4;
    localparam int W   = 8;
    localparam int LAT = 32 * (1 + S + W + 1) + 32 + 2;
    localparam logic [4:0] TD = 5'd0;

    logic        adc_clk = 1'b0;
    logic        adc_resetn = 1'b0;
    logic        cal_start = 1'b0;
    logic        iodelay_ready = 1'b1;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [63:0] iodelay_data;
    logic        iodelay_load, cal_busy, cal_done;
    logic [7:0]  cal_error;

    ad9467_iodelay_cal #(.SETTLE_CYCLES(S), .WINDOW(W), .TAP_DEFAULT(TD)) dut (
        .adc_clk(adc_clk), .adc_resetn(adc_resetn), .cal_start(cal_start),
        .iodelay_ready(iodelay_ready), .adc_data(adc_data), .adc_valid(adc_valid),
        .iodelay_data(iodelay_data), .iodelay_load(iodelay_load), .cal_busy(cal_busy),
        .cal_done(cal_done), .cal_error(cal_error)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  err;
        int          lat;
        int          loads;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0, n_bad = 0;
    int          cyc = 0;
    logic [31:0] mask [8];
    int          fmode [8];
    int          vmode = 0;
    bit          stall_on = 1'b0;
    logic [4:0]  cur_tap = '0;

    always @(posedge adc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Longest passing run (first wins on ties) by scanning every start; returns {err, tap}
    function automatic logic [5:0] model_tap(input logic [31:0] m);
        int bl = 0, bs = 0;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while ((s + l < 32) && m[s + l]) l++;
            if (l > bl) begin bl = l; bs = s; end
        end
        if (bl == 0) return {1'b1, TD};
        return {1'b0, 5'(bs + (bl - 1) / 2)};
    endfunction

    function automatic logic [1:0] fail_bits(input int m, input int sc);
        case (m)
            0:       return 2'b11;
            1:       return 2'b00;
            2:       return 2'b01;
            default: return ((sc / 2) % 2 != 0) ? 2'b10 : 2'b01;
        endcase
    endfunction

    function automatic logic [31:0] rand_mask();
        logic [63:0] t;
        int a, b;
        case ($urandom_range(4))
            0: return $urandom;
            1, 2: begin
                a = $urandom_range(31); b = $urandom_range(31, a);
                t = ((64'd1 << (b - a + 1)) - 64'd1) << a;
                a = $urandom_range(31); b = $urandom_range(31, a);
                if ($urandom_range(1) == 1) t = t | (((64'd1 << (b - a + 1)) - 64'd1) << a);
                return t[31:0];
            end
            3: return 32'h0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // ADC model: the IDELAY tap follows every load pulse; drives at #2 after the edge
    initial begin : drv
        bit         ph = 1'b0;
        int         sc = 0;
        logic [15:0] d;
        forever begin
            @(posedge adc_clk); #2;
            if (iodelay_load) cur_tap = iodelay_data[4:0];
            if (stall_on)        adc_valid = 1'b0;
            else if (vmode == 0) adc_valid = 1'b1;
            else                 adc_valid = ($urandom_range(3) != 0);
            if (adc_valid) begin
                ph = ~ph; sc++;
                d = '0;
                for (int i = 0; i < 8; i++)
                    d[2*i +: 2] = mask[i][cur_tap] ? (ph ? 2'b10 : 2'b01) : fail_bits(fmode[i], sc);
                adc_data = d;
            end else begin
                adc_data = 16'($urandom);
            end
        end
    end

    // Monitor: counts load pulses per run and scores each completion
    initial begin : mon
        bit   done_p = 1'b0, busy_p = 1'b0;
        int   loads = 0;
        exp_t e;
        forever begin
            @(negedge adc_clk);
            if (!adc_resetn) begin
                done_p = 1'b0; busy_p = 1'b0; loads = 0;
            end else begin
                if (cal_busy && !busy_p) loads = 0;
                if (iodelay_load) begin
                    loads++;
                    chk("reserved_bits", iodelay_data & ~64'h1F1F1F1F1F1F1F1F, 64'h0);
                end
                if (cal_done && !done_p) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_done: got cal_done=1 expected no completion");
                    end else begin
                        e = exp_q.pop_front();
                        chk("cal_error", cal_error, e.err);
                        chk("iodelay_data", iodelay_data, e.data);
                        chk("load_count", loads, e.loads);
                        chk("busy_at_done", cal_busy, 1'b0);
                        if (e.lat >= 0) chk("latency", cyc - e.start_cyc, e.lat);
                    end
                end
                done_p = cal_done; busy_p = cal_busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    task automatic build_exp(output exp_t e);
        logic [5:0] r;
        e.data = '0; e.err = '0;
        for (int i = 0; i < 8; i++) begin
            r = model_tap(mask[i]);
            e.data[8*i +: 5] = r[4:0];
            e.err[i] = r[5];
        end
        e.loads = 33;
        e.lat = (vmode == 0) ? LAT : -1;
        e.start_cyc = 0;
    endtask

    task automatic launch(input exp_t e);
        exp_t x;
        x = e;
        x.start_cyc = cyc;
        exp_q.push_back(x);
        cal_start = 1'b1; tick(1); cal_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: got %0d pending completions expected 0", exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic wait_load_tap(input int t, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (iodelay_load && iodelay_data[4:0] == 5'(t)) break;
            tick(1);
        end
        if (i == budget) begin
            n_vec++; n_bad++;
            $display("FAIL load_timeout: got no load of tap %0d expected one", t);
        end
    endtask

    task automatic run_masks(input int budget);
        exp_t e;
        build_exp(e);
        launch(e);
        wait_idle(budget);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"},  iodelay_data, {8{3'b0, TD}});
        chk({tag, "_load"},  iodelay_load, 1'b0);
        chk({tag, "_busy"},  cal_busy, 1'b0);
        chk({tag, "_done"},  cal_done, 1'b0);
        chk({tag, "_error"}, cal_error, 8'h00);
    endtask

    initial begin : main
        exp_t e;
        int   seen;
        for (int i = 0; i < 8; i++) begin mask[i] = '0; fmode[i] = 0; end
        adc_resetn = 1'b0; tick(3);
        chk_reset("rst");
        adc_resetn = 1'b1; tick(1);
        chk_reset("post_rst");

        // Start without IDELAYCTRL ready is ignored
        iodelay_ready = 1'b0; cal_start = 1'b1; tick(1); cal_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (cal_busy || iodelay_load || cal_done) seen++;
            tick(1);
        end
        chk("no_ready_ignored", seen, 0);
        iodelay_ready = 1'b1; tick(2);

        // All lanes pass taps 10..20
        for (int i = 0; i < 8; i++) begin mask[i] = 32'h001F_FC00; fmode[i] = $urandom_range(3); end
        run_masks(2 * LAT);

        // Lane 3 stuck at 2'b11, others pass everywhere
        for (int i = 0; i < 8; i++) mask[i] = 32'hFFFF_FFFF;
        mask[3] = 32'h0; fmode[3] = 0;
        run_masks(2 * LAT);

        // Lane 0 window selection cases
        for (int i = 1; i < 8; i++) begin mask[i] = rand_mask(); fmode[i] = $urandom_range(3); end
        mask[0] = 32'h0FF0_003C; run_masks(2 * LAT);
        mask[0] = 32'h00F0_003C; run_masks(2 * LAT);
        mask[0] = 32'h8000_0000; run_masks(2 * LAT);

        // Settle on tap 10 everywhere, then abort during tap 7 check
        for (int i = 0; i < 8; i++) mask[i] = 32'h0000_1F00;
        run_masks(2 * LAT);
        e.data = 64'h0A0A0A0A0A0A0A0A; e.err = 8'hFF; e.loads = 9; e.lat = -1; e.start_cyc = 0;
        launch(e);
        wait_load_tap(7, 20 * (S + W + 2));
        tick(S + 2);
        iodelay_ready = 1'b0; tick(1);
        chk("abort_load", iodelay_load, 1'b1);
        chk("abort_data", iodelay_data, 64'h0A0A0A0A0A0A0A0A);
        chk("abort_done", cal_done, 1'b1);
        chk("abort_busy", cal_busy, 1'b0);
        tick(2); iodelay_ready = 1'b1;
        wait_idle(20);

        // adc_valid stall of 100 cycles inside a check window, start pulses while busy
        for (int i = 0; i < 8; i++) begin mask[i] = rand_mask(); fmode[i] = $urandom_range(3); end
        build_exp(e); e.lat = LAT + 100;
        launch(e);
        wait_load_tap(3, 10 * (S + W + 2));
        cal_start = 1'b1; tick(1); cal_start = 1'b0;
        chk("busy_start_ignored", cal_busy, 1'b1);
        wait_load_tap(5, 10 * (S + W + 2));
        tick(S + 2);
        stall_on = 1'b1; tick(50);
        cal_start = 1'b1; tick(1); cal_start = 1'b0;
        tick(49); stall_on = 1'b0;
        wait_idle(2 * LAT);

        // Reset in the middle of a sweep
        launch(e);
        exp_q.delete();
        tick(60);
        adc_resetn = 1'b0; tick(1);
        chk_reset("midop_rst");
        adc_resetn = 1'b1; tick(2);

        // Randomized masks, failure modes and valid gaps
        vmode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin mask[i] = rand_mask(); fmode[i] = $urandom_range(3); end
            run_masks(3 * LAT);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
